// File: rtl/counter_monitor.sv
// Cycle-accurate checker for an up/down loadable counter: predicts the next
// count from the observed stimulus and flags count or flag mismatches.
module counter_monitor #(
    parameter int WIDTH       = 4,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_en,
    input  logic             clr,
    input  logic             dut_rst_n,
    input  logic             load_n,
    input  logic             ce,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             err,
    output logic             err_pulse,
    output logic [15:0]      err_count,
    output logic [15:0]      chk_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic [1:0]       first_type,
    output logic [15:0]      first_cyc,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] exp_reg, exp_next;
    logic [WIDTH-1:0] base, model_next;
    logic [15:0]      cyc_reg;
    logic             err_reg, err_pulse_reg;
    logic [WIDTH-1:0] first_exp_reg, first_act_reg;
    logic [1:0]       first_type_reg;
    logic [15:0]      first_cyc_reg;

    logic compare, cnt_mismatch, flag_mismatch, mismatch, record;
    logic [1:0] sat_inc;

    // A cycle is compared only when the observed counter is out of reset.
    assign compare       = mon_en && (state_reg == CHECK) && dut_rst_n;
    assign cnt_mismatch  = compare && (count_out != exp_reg);
    assign flag_mismatch = compare && ((max_count != (&count_out)) || (zero != ~|count_out));
    assign mismatch      = cnt_mismatch || flag_mismatch;
    // clr takes precedence: a mismatch in the clearing cycle is discarded.
    assign record        = mismatch && !clr;

    // SYNC seeds the prediction from the live counter; CHECK runs free on exp.
    always_comb begin
        base = (state_reg == SYNC) ? count_out : exp_reg;
        if (!dut_rst_n) begin
            model_next = '0;
        end else if (!load_n) begin
            model_next = data_load;
        end else if (ce && up_down) begin
            model_next = base + WIDTH'(1);
        end else if (ce) begin
            model_next = base - WIDTH'(1);
        end else begin
            model_next = base;
        end
    end

    always_comb begin
        exp_next = exp_reg;
        if ((state_reg == SYNC) || (state_reg == CHECK)) begin
            exp_next = model_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  state_next = SYNC;
            SYNC:  state_next = CHECK;
            CHECK: if (STOP_ON_ERR && record) state_next = HALT;
            HALT:  if (clr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!mon_en) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            exp_reg   <= '0;
            cyc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            exp_reg   <= exp_next;
            cyc_reg   <= cyc_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg        <= 1'b0;
            err_pulse_reg  <= 1'b0;
            first_exp_reg  <= '0;
            first_act_reg  <= '0;
            first_type_reg <= '0;
            first_cyc_reg  <= '0;
        end else begin
            err_pulse_reg <= record;
            if (clr) begin
                err_reg        <= 1'b0;
                first_exp_reg  <= '0;
                first_act_reg  <= '0;
                first_type_reg <= '0;
                first_cyc_reg  <= '0;
            end else if (record) begin
                err_reg <= 1'b1;
                if (!err_reg) begin
                    first_exp_reg  <= exp_reg;
                    first_act_reg  <= count_out;
                    first_type_reg <= {flag_mismatch, cnt_mismatch};
                    first_cyc_reg  <= cyc_reg;
                end
            end
        end
    end

    // Saturating event counters: index 0 counts compares, index 1 errors.
    assign sat_inc = {record, compare && !clr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_reg <= '0;
                end else if (sat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign chk_count  = g_sat[0].cnt_reg;
    assign err_count  = g_sat[1].cnt_reg;
    assign err        = err_reg;
    assign err_pulse  = err_pulse_reg;
    assign first_exp  = first_exp_reg;
    assign first_act  = first_act_reg;
    assign first_type = first_type_reg;
    assign first_cyc  = first_cyc_reg;
    assign state      = state_reg;

endmodule
